// File: rtl/stream_mux_rr.sv
// N-channel round-robin streaming mux with valid/ready handshakes and a registered one-entry output stage.
// Optional packet locking (in_last/out_last) is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N-1:0]       in_last,
    output logic               out_last
`endif
);

    logic               r_outValid;
    logic [WIDTH-1:0]   r_outData;
    logic [SEL_W-1:0]   r_outSel;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_load;
    logic               w_xfer;
    logic               w_scanValid;
    logic [SEL_W-1:0]   w_scanGrant;
    logic               w_grantValid;
    logic [SEL_W-1:0]   w_grant;
    logic [WIDTH-1:0]   w_grantData;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic               r_outLast;
    logic               r_locked;
    logic [SEL_W-1:0]   r_lockCh;
`endif

    assign w_load = !r_outValid || out_ready;

    // Walk downward so the lowest offset after r_ptr wins: priority ptr+1 first, ptr itself last.
    always_comb begin
        int idx;
        idx         = 0;
        w_scanValid = 1'b0;
        w_scanGrant = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % N;
            if (in_valid[idx]) begin
                w_scanValid = 1'b1;
                w_scanGrant = SEL_W'(idx);
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign w_grantValid = r_locked ? in_valid[r_lockCh] : w_scanValid;
    assign w_grant      = r_locked ? r_lockCh : w_scanGrant;
`else
    assign w_grantValid = w_scanValid;
    assign w_grant      = w_scanGrant;
`endif

    assign w_xfer      = w_load && w_grantValid && !rst;
    assign w_grantData = in_data[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    // Output register reloads whenever it is empty or being drained; otherwise it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSel   <= '0;
            r_ptr      <= SEL_W'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            r_outLast  <= 1'b0;
            r_locked   <= 1'b0;
            r_lockCh   <= '0;
`endif
        end else if (w_load) begin
            if (w_grantValid) begin
                r_outValid <= 1'b1;
                r_outData  <= w_grantData;
                r_outSel   <= w_grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
                r_outLast  <= in_last[w_grant];
                // Pointer only advances once the whole packet has gone through.
                if (in_last[w_grant]) begin
                    r_locked <= 1'b0;
                    r_ptr    <= w_grant;
                end else begin
                    r_locked <= 1'b1;
                    r_lockCh <= w_grant;
                end
`else
                r_ptr      <= w_grant;
`endif
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_sel   = r_outSel;
`ifdef STREAM_MUX_PKT_LOCK_EN
    assign out_last  = r_outLast;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, WIDTH=8) using a behavioural model and a scoreboard queue.
// Packet-lock steps are compiled in when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
    logic [N-1:0]   tbLast;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
    assign in_last = tbLast;
`endif

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } expWord_t;

    expWord_t sbQ[$];
    int       testsRun;
    int       testsFailed;
    int       mPtr;
    bit       mOutValid;
    bit       mLocked;
    int       mLockCh;

    stream_mux_rr #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic [3:0] valid, input logic [31:0] data,
                                 input logic outRdy, input logic [3:0] last);
        rst       = rstV;
        in_valid  = valid;
        in_data   = data;
        out_ready = outRdy;
        tbLast    = last;
    endtask

    function automatic int modelGrant();
        int idx;
        if (mLocked) return in_valid[mLockCh] ? mLockCh : -1;
        for (int k = 1; k <= N; k++) begin
            idx = (mPtr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check combinational ready and the held output at negedge, then advance the model.
    task automatic stepCycle();
        bit         load;
        int         g;
        logic [3:0] expReady;
        expWord_t   w;
        @(negedge clk);
        load     = !mOutValid || out_ready;
        g        = modelGrant();
        expReady = 4'b0;
        if (!rst && load && g >= 0) expReady[g] = 1'b1;
        checkOutput("inReady", 32'(in_ready), 32'(expReady));
        checkOutput("outValid", 32'(out_valid), 32'(mOutValid));
        if (mOutValid && sbQ.size() > 0) begin
            checkOutput("sbSel", 32'(out_sel), 32'(sbQ[0].sel));
            checkOutput("sbData", 32'(out_data), 32'(sbQ[0].data));
`ifdef STREAM_MUX_PKT_LOCK_EN
            checkOutput("sbLast", 32'(out_last), 32'(sbQ[0].last));
`endif
            if (out_ready) void'(sbQ.pop_front());
        end
        if (rst) begin
            sbQ.delete();
            mOutValid = 1'b0;
            mPtr      = N - 1;
            mLocked   = 1'b0;
        end else if (load) begin
            if (g >= 0) begin
                w.sel  = 2'(g);
                w.data = in_data[g*W +: W];
                w.last = tbLast[g];
                sbQ.push_back(w);
                mOutValid = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
                if (tbLast[g]) begin
                    mLocked = 1'b0;
                    mPtr    = g;
                end else begin
                    mLocked = 1'b1;
                    mLockCh = g;
                end
`else
                mPtr = g;
`endif
            end else begin
                mOutValid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        mPtr        = N - 1;
        mOutValid   = 1'b0;
        mLocked     = 1'b0;
        mLockCh     = 0;

        // Reset held for two cycles with no traffic.
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1, 4'b1111);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1, 4'b1111);
        checkOutput("rstOutValid", 32'(out_valid), 32'h0);
        checkOutput("rstOutData", 32'(out_data), 32'h0);
        checkOutput("rstOutSel", 32'(out_sel), 32'h0);
        stepCycle();

        // Single channel 2 carrying A5.
        applyStimulus(1'b0, 4'b0100, 32'h00A5_0000, 1'b1, 4'b1111);
        stepCycle();
        checkOutput("singleValid", 32'(out_valid), 32'h1);
        checkOutput("singleData", 32'(out_data), 32'hA5);
        checkOutput("singleSel", 32'(out_sel), 32'h2);
        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1, 4'b1111);
        stepCycle();

        // Fresh reset so rotation starts at channel 0, then all channels valid.
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1, 4'b1111);
        stepCycle();
        applyStimulus(1'b0, 4'b1111, 32'h0302_0100, 1'b1, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            checkOutput("rrSel", 32'(out_sel), 32'(i % N));
            checkOutput("rrData", 32'(out_data), 32'(i % N));
        end

        // Drain, load 3C under backpressure, then hold for three cycles.
        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1, 4'b1111);
        stepCycle();
        applyStimulus(1'b0, 4'b0001, 32'h0000_003C, 1'b0, 4'b1111);
        stepCycle();
        applyStimulus(1'b0, 4'b1111, 32'h3322_113C, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("bpData", 32'(out_data), 32'h3C);
            checkOutput("bpSel", 32'(out_sel), 32'h0);
        end
        applyStimulus(1'b0, 4'b1111, 32'h3322_113C, 1'b1, 4'b1111);
        stepCycle();
        checkOutput("bpNextSel", 32'(out_sel), 32'h1);
        checkOutput("bpNextData", 32'(out_data), 32'h11);

        // Reset while a word is stalled; first grant afterwards must be channel 1.
        applyStimulus(1'b1, 4'b1010, 32'h4400_2200, 1'b0, 4'b1111);
        stepCycle();
        checkOutput("midRstValid", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 4'b1010, 32'h4400_2200, 1'b1, 4'b1111);
        stepCycle();
        checkOutput("midRstSel", 32'(out_sel), 32'h1);
        checkOutput("midRstData", 32'(out_data), 32'h22);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Three-beat packet on channel 1 while channel 0 keeps requesting.
        applyStimulus(1'b0, 4'b0010, 32'h0000_B000, 1'b1, 4'b0000);
        stepCycle();
        checkOutput("lockSel0", 32'(out_sel), 32'h1);
        checkOutput("lockLast0", 32'(out_last), 32'h0);
        applyStimulus(1'b0, 4'b0011, 32'h0000_B1C0, 1'b1, 4'b0000);
        stepCycle();
        checkOutput("lockSel1", 32'(out_sel), 32'h1);
        checkOutput("lockLast1", 32'(out_last), 32'h0);
        applyStimulus(1'b0, 4'b0011, 32'h0000_B2C0, 1'b1, 4'b0010);
        stepCycle();
        checkOutput("lockSel2", 32'(out_sel), 32'h1);
        checkOutput("lockLast2", 32'(out_last), 32'h1);
        applyStimulus(1'b0, 4'b0001, 32'h0000_00C0, 1'b1, 4'b0001);
        stepCycle();
        checkOutput("lockSel3", 32'(out_sel), 32'h0);
        checkOutput("lockData3", 32'(out_data), 32'hC0);
`endif

        // Drain whatever remains.
        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1, 4'b1111);
        stepCycle();
        stepCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
